// File: rtl/game_master.sv
// game_master: runs one falling-block game, offering LFSR pieces to a placement client
// and forwarding the chosen move to a placement engine; tracks board and statistics.
// Outputs are registered; the client has TIMEOUT_CYCLES to answer, the engine has no limit.
module game_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_PIECES     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  seed,
  output logic         req_to_client,
  output logic [3:0]   cur_block,
  output logic [199:0] cur_board,
  input  logic         resp_from_client,
  input  logic [3:0]   opt_col,
  input  logic [1:0]   opt_rotation,
  output logic         apply_req,
  output logic [3:0]   apply_block,
  output logic [3:0]   apply_col,
  output logic [1:0]   apply_rot,
  input  logic         apply_done,
  input  logic         apply_valid,
  input  logic [199:0] apply_board,
  input  logic [2:0]   apply_lines,
  output logic         busy,
  output logic         game_over,
  output logic         timeout_err,
  output logic [15:0]  piece_count,
  output logic [15:0]  lines_total
);

  // The wait counter runs 0..TIMEOUT_CYCLES-1; the last value is the final cycle a response may land.
  localparam int                CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]       PIECE_LIMIT = 16'(MAX_PIECES);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_REQ, S_WAIT_RESP, S_APPLY, S_WAIT_APPLY, S_CHECK, S_DONE
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [16:0]      lines_sum;
  logic [CNT_W-1:0] wait_cnt;

  // Next LFSR value (taps 16,14,13,11) and the widened line sum used for saturation.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    lines_sum = {1'b0, lines_total} + {14'd0, apply_lines};
  end

  // Game sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lfsr          <= '0;
      wait_cnt      <= '0;
      req_to_client <= 1'b0;
      cur_block     <= '0;
      cur_board     <= '0;
      apply_req     <= 1'b0;
      apply_block   <= '0;
      apply_col     <= '0;
      apply_rot     <= '0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      timeout_err   <= 1'b0;
      piece_count   <= '0;
      lines_total   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_GEN;
            busy        <= 1'b1;
            cur_board   <= '0;
            piece_count <= '0;
            lines_total <= '0;
            game_over   <= 1'b0;
            timeout_err <= 1'b0;
            lfsr        <= (seed == 16'h0000) ? 16'hACE1 : seed;
          end
        end
        S_GEN: begin
          // A candidate of 7 is not a valid piece; keep stepping until one is.
          lfsr <= lfsr_next;
          if (lfsr_next[2:0] != 3'd7) begin
            cur_block     <= {1'b0, lfsr_next[2:0]};
            req_to_client <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          req_to_client <= 1'b0;
          wait_cnt      <= '0;
          state         <= S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          // A response on the limit cycle takes priority over the timeout.
          if (resp_from_client) begin
            apply_col   <= opt_col;
            apply_rot   <= opt_rotation;
            apply_block <= cur_block;
            state       <= S_APPLY;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_APPLY: begin
          apply_req <= 1'b1;
          state     <= S_WAIT_APPLY;
        end
        S_WAIT_APPLY: begin
          if (apply_done) begin
            apply_req <= 1'b0;
            if (!apply_valid) begin
              game_over <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else begin
              cur_board   <= apply_board;
              piece_count <= (piece_count == 16'hFFFF) ? 16'hFFFF : piece_count + 16'd1;
              lines_total <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
              state       <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // Anything left in the top row means the stack has topped out.
          if (|cur_board[9:0]) begin
            game_over <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else if ((MAX_PIECES != 0) && (piece_count == PIECE_LIMIT)) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_GEN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_master.sv
// Bench for game_master: directed games driven by a client/engine stimulus process,
// checked every cycle against a transaction-level game model plus a few literal values.
module tb_game_master;
  localparam int TMO  = 8;
  localparam int MAXP = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  seed = 16'h0000;
  logic         req_to_client;
  logic [3:0]   cur_block;
  logic [199:0] cur_board;
  logic         resp_from_client = 1'b0;
  logic [3:0]   opt_col = 4'd0;
  logic [1:0]   opt_rotation = 2'd0;
  logic         apply_req;
  logic [3:0]   apply_block;
  logic [3:0]   apply_col;
  logic [1:0]   apply_rot;
  logic         apply_done = 1'b0;
  logic         apply_valid = 1'b0;
  logic [199:0] apply_board = '0;
  logic [2:0]   apply_lines = 3'd0;
  logic         busy;
  logic         game_over;
  logic         timeout_err;
  logic [15:0]  piece_count;
  logic [15:0]  lines_total;

  // Game model, written by the stimulus process.
  int           game_id = 0;
  logic [15:0]  m_seed = 16'h0000;
  logic [199:0] m_board = '0;
  logic [15:0]  m_pc = 16'd0;
  logic [15:0]  m_lines = 16'd0;
  bit           m_go = 1'b0;
  bit           m_to = 1'b0;
  logic [3:0]   m_col = 4'd0;
  logic [1:0]   m_rot = 2'd0;
  int           m_served = 0;
  int           tmo_cnt = 0;
  bit           end_req = 1'b0;
  logic [199:0] brd_a = '0;
  logic [199:0] brd_b = '0;
  logic [199:0] brd_c = '0;

  // State owned by the compare process.
  int           nvec = 0;
  int           nerr = 0;
  logic [15:0]  c_lfsr = 16'h0000;
  logic [3:0]   exp_blk = 4'd0;
  int           c_gid = 0;
  int           req_in_game = 0;
  int           since_req = 100;
  bit           hold = 1'b0;
  bit           prev_req = 1'b0;
  bit           prev_busy = 1'b0;
  bit           done_pend = 1'b0;

  game_master #(.TIMEOUT_CYCLES(TMO), .MAX_PIECES(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .req_to_client(req_to_client), .cur_block(cur_block), .cur_board(cur_board),
    .resp_from_client(resp_from_client), .opt_col(opt_col), .opt_rotation(opt_rotation),
    .apply_req(apply_req), .apply_block(apply_block), .apply_col(apply_col), .apply_rot(apply_rot),
    .apply_done(apply_done), .apply_valid(apply_valid), .apply_board(apply_board),
    .apply_lines(apply_lines), .busy(busy), .game_over(game_over), .timeout_err(timeout_err),
    .piece_count(piece_count), .lines_total(lines_total)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Hand-derived piece sequence for seed 16'h0001: 0002, 0004, 0008 -> pieces 2, 4, 0.
  function automatic logic [3:0] lit_seed1(input int idx);
    case (idx)
      0:       return 4'd2;
      1:       return 4'd4;
      2:       return 4'd0;
      default: return 4'hF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: dut=%0h model=%0h", nm, act, exp);
    end
  endtask

  // Compare process: all checks happen here, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (end_req) begin
        chk("wait_bounds", 200'(tmo_cnt), 200'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
      end else if (!rst_n) begin
        chk("rst_board", cur_board, '0);
        chk("rst_outputs", 200'({req_to_client, cur_block, apply_req, apply_block, apply_col,
                                 apply_rot, busy, game_over, timeout_err, piece_count, lines_total}),
            200'(0));
        hold = 1'b0; prev_req = 1'b0; prev_busy = 1'b0; done_pend = 1'b0;
      end else begin
        if (game_id != c_gid) begin
          c_gid = game_id;
          c_lfsr = (m_seed == 16'h0000) ? 16'hACE1 : m_seed;
          req_in_game = 0;
        end
        if (done_pend) chk("apply_req_drop", 200'(apply_req), 200'(0));
        done_pend = apply_done;
        if (apply_done) chk("apply_req_hold", 200'(apply_req), 200'(1));
        if (req_to_client) begin
          chk("req_width", 200'(prev_req), 200'(0));
          do c_lfsr = lfsr_step(c_lfsr); while (c_lfsr[2:0] == 3'd7);
          exp_blk = {1'b0, c_lfsr[2:0]};
          if (game_id == 1) chk("lit_seed1_piece", 200'(cur_block), 200'(lit_seed1(req_in_game)));
          if (game_id == 2 && req_in_game == 0) chk("lit_seed0_piece", 200'(cur_block), 200'(4'd3));
          req_in_game++;
          since_req = 0;
          hold = 1'b1;
          chk("req_block", 200'(cur_block), 200'(exp_blk));
          chk("req_board", cur_board, m_board);
          chk("req_stats", 200'({busy, piece_count, lines_total, game_over, timeout_err}),
              200'({1'b1, m_pc, m_lines, 2'b00}));
        end else begin
          if (since_req < 100) since_req++;
          if (hold && (apply_req || !busy)) hold = 1'b0;
          if (hold) chk("offer_stable", 200'({busy, cur_block, cur_board}), 200'({1'b1, exp_blk, m_board}));
          if (m_to && since_req == TMO) chk("busy_at_limit", 200'(busy), 200'(1));
          if (m_to && since_req == TMO + 1)
            chk("timeout_after_limit", 200'({busy, timeout_err, game_over}), 200'(3'b010));
        end
        if (apply_req)
          chk("apply_fields", 200'({apply_block, apply_col, apply_rot}), 200'({exp_blk, m_col, m_rot}));
        if (prev_busy && !busy) begin
          chk("end_flags", 200'({game_over, timeout_err}), 200'({m_go, m_to}));
          chk("end_stats", 200'({piece_count, lines_total}), 200'({m_pc, m_lines}));
          chk("end_board", cur_board, m_board);
          chk("end_requests", 200'(req_in_game), 200'(m_served));
          if (game_id == 1)
            chk("lit_game1_end", 200'({piece_count, lines_total, game_over}), 200'({16'd3, 16'd3, 1'b0}));
        end
        prev_req = req_to_client;
        prev_busy = busy;
      end
    end
  end

  task automatic start_game(input logic [15:0] s, input int gid);
    @(posedge clk); #1;
    m_seed = s; game_id = gid;
    m_board = '0; m_pc = 16'd0; m_lines = 16'd0; m_go = 1'b0; m_to = 1'b0; m_served = 0;
    seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req_to_client) got = 1'b1;
    end
    if (!got) tmo_cnt++;
  endtask

  task automatic wait_apply(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (apply_req) got = 1'b1;
    end
    if (!got) tmo_cnt++;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) tmo_cnt++;
  endtask

  // Client answers dly cycles after the request pulse.
  task automatic client(input int dly, input logic [3:0] c, input logic [1:0] r);
    bit got;
    wait_req(got);
    if (got) begin
      m_served++;
      repeat (dly) @(posedge clk);
      #1;
      resp_from_client = 1'b1; opt_col = c; opt_rotation = r;
      m_col = c; m_rot = r;
      @(posedge clk); #1;
      resp_from_client = 1'b0; opt_col = 4'd0; opt_rotation = 2'd0;
    end
  endtask

  // Engine completes lat cycles after seeing apply_req; stray adds a late client pulse.
  task automatic engine(input bit vld, input logic [199:0] brd, input logic [2:0] ln,
                        input int lat, input bit stray);
    bit got;
    wait_apply(got);
    if (got) begin
      if (stray) begin
        @(posedge clk); #1;
        resp_from_client = 1'b1; opt_col = 4'd9; opt_rotation = 2'd1;
        @(posedge clk); #1;
        resp_from_client = 1'b0; opt_col = 4'd0; opt_rotation = 2'd0;
      end
      repeat (lat) @(posedge clk);
      #1;
      apply_done = 1'b1; apply_valid = vld; apply_board = brd; apply_lines = ln;
      if (vld) begin
        m_board = brd;
        if (m_pc != 16'hFFFF) m_pc = m_pc + 16'd1;
        if (int'(m_lines) + int'(ln) > 65535) m_lines = 16'hFFFF;
        else m_lines = m_lines + 16'(ln);
        if (brd[9:0] != 10'd0) m_go = 1'b1;
      end else begin
        m_go = 1'b1;
      end
      @(posedge clk); #1;
      apply_done = 1'b0; apply_valid = 1'b0; apply_board = '0; apply_lines = 3'd0;
    end
  endtask

  // Stimulus process.
  initial begin
    bit got;
    brd_a[191:190] = 2'b11;
    brd_b = brd_a;
    brd_b[180] = 1'b1;
    brd_c[199:190] = 10'h3FF;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Seed 1, three pieces to the piece limit; second answer lands on the last allowed cycle.
    start_game(16'h0001, 1);
    client(5, 4'd3, 2'd2);
    engine(1'b1, '0, 3'd2, 2, 1'b1);
    client(TMO, 4'd1, 2'd1);
    engine(1'b1, brd_a, 3'd1, 1, 1'b0);
    client(1, 4'd7, 2'd3);
    engine(1'b1, brd_b, 3'd0, 3, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);

    // Seed 0 falls back to ACE1; silent client times out; start while busy is ignored.
    start_game(16'h0000, 2);
    m_to = 1'b1;
    wait_req(got);
    if (got) m_served++;
    repeat (3) @(posedge clk);
    #1 seed = 16'h7777; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);

    // Illegal move ends the game and leaves the board as it was.
    start_game(16'h0005, 3);
    client(2, 4'd5, 2'd1);
    engine(1'b1, brd_c, 3'd0, 2, 1'b0);
    client(1, 4'd0, 2'd0);
    engine(1'b0, {200{1'b1}}, 3'd7, 1, 1'b0);
    wait_idle();
    repeat (2) @(posedge clk);

    // A cell in the top row ends the game after the check.
    start_game(16'hBEEF, 4);
    client(1, 4'd2, 2'd3);
    engine(1'b1, 200'h20, 3'd4, 1, 1'b0);
    wait_idle();
    repeat (2) @(posedge clk);

    // Reset while waiting on the engine, then a fresh game.
    start_game(16'h1234, 5);
    client(2, 4'd4, 2'd0);
    wait_apply(got);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_game(16'h1234, 6);
    m_to = 1'b1;
    wait_req(got);
    if (got) m_served++;
    wait_idle();
    repeat (2) @(posedge clk);
    end_req = 1'b1;
  end

endmodule
